set_injector: RTL and testbench

Synthesizable command-driven signal injector. It holds a bank of `SET_SIZE` named output channels, each `SET_WIDTH` bits wide. An ASCII alias in each command selects a channel by lookup against a per-channel alias table, and the command data is written to that channel. Every channel is presented twice: as an immediate (asynch) copy and as a clock-resynchronized (synch) copy. It sits between a command sequencer and the logic under stimulus, and gates command acceptance until a programmable post-reset delay has elapsed.

---
 rtl/set_injector_pkg.sv | 19 +
 rtl/set_injector_alias_match.sv | 27 ++
 rtl/set_injector.sv | 98 +++++++++
 tb/tb_set_injector.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/set_injector_pkg.sv
// Shared defaults and the alias-packing helper for the set_injector block.
package set_injector_pkg;

    localparam int C_SET_SIZE  = 5;
    localparam int C_SET_WIDTH = 32;
    localparam int C_ALIAS_W   = 64;
    localparam int C_WAIT_RST  = 4;

    // Packs an ASCII name right-justified into an alias word; last character lands in the LSB byte.
    function automatic logic [C_ALIAS_W-1:0] pack_alias(input string s);
        logic [C_ALIAS_W-1:0] v;
        v = '0;
        for (int i = 0; i < s.len() && i < C_ALIAS_W / 8; i++) begin
            v = {v[C_ALIAS_W-9:0], s[i]};
        end
        return v;
    endfunction

endpackage

// File: rtl/set_injector_alias_match.sv
// Combinational alias lookup: exact compare against every table entry, lowest index wins.
module set_injector_alias_match
    import set_injector_pkg::*;
#(
    parameter int SET_SIZE = C_SET_SIZE,
    parameter int ALIAS_W  = C_ALIAS_W,
    parameter int IDX_W    = (SET_SIZE > 1) ? $clog2(SET_SIZE) : 1
) (
    input  logic [SET_SIZE*ALIAS_W-1:0] set_alias,
    input  logic [ALIAS_W-1:0]          cmd_alias,
    output logic                        match,
    output logic [IDX_W-1:0]            idx
);

    // Scanning from the top down lets the lowest matching index overwrite any higher one.
    always_comb begin
        match = 1'b0;
        idx   = '0;
        for (int i = SET_SIZE - 1; i >= 0; i--) begin
            if (set_alias[i*ALIAS_W +: ALIAS_W] == cmd_alias) begin
                match = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/set_injector.sv
// Command-driven channel injector: alias-addressed writes into an immediate bank plus a
// one-clock resynchronized copy, with command acceptance gated by a post-reset delay.
module set_injector
    import set_injector_pkg::*;
#(
    parameter int SET_SIZE  = C_SET_SIZE,
    parameter int SET_WIDTH = C_SET_WIDTH,
    parameter int ALIAS_W   = C_ALIAS_W,
    parameter int WAIT_RST  = C_WAIT_RST,
    parameter logic [SET_SIZE*SET_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [SET_SIZE*ALIAS_W-1:0]   set_alias,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [ALIAS_W-1:0]            cmd_alias,
    input  logic [SET_WIDTH-1:0]          cmd_data,
    output logic                          cmd_done,
    output logic                          cmd_err,
    output logic [SET_SIZE*SET_WIDTH-1:0] set_signals_asynch,
    output logic [SET_SIZE*SET_WIDTH-1:0] set_signals_synch
);

    localparam int IDX_W = (SET_SIZE > 1) ? $clog2(SET_SIZE) : 1;

    logic [7:0]                    cnt_q,    cnt_d;
    logic                          ready_q,  ready_d;
    logic                          done_q,   done_d;
    logic                          err_q,    err_d;
    logic [SET_SIZE*SET_WIDTH-1:0] asynch_q, asynch_d;
    logic [SET_SIZE*SET_WIDTH-1:0] synch_q;

    logic             match;
    logic [IDX_W-1:0] idx;
    logic             accept;

    set_injector_alias_match #(
        .SET_SIZE (SET_SIZE),
        .ALIAS_W  (ALIAS_W),
        .IDX_W    (IDX_W)
    ) u_alias_match (
        .set_alias (set_alias),
        .cmd_alias (cmd_alias),
        .match     (match),
        .idx       (idx)
    );

    assign accept = cmd_valid && ready_q;

    // Counter freezes once ready is up, so it never wraps back into the waiting window.
    always_comb begin
        cnt_d   = cnt_q;
        ready_d = ready_q;
        if (!ready_q) begin
            cnt_d = 8'(cnt_q + 8'd1);
            if (cnt_d == 8'(WAIT_RST)) begin
                ready_d = 1'b1;
            end
        end
    end

    always_comb begin
        asynch_d = asynch_q;
        done_d   = accept && match;
        err_d    = accept && !match;
        for (int i = 0; i < SET_SIZE; i++) begin
            if (accept && match && (idx == IDX_W'(i))) begin
                asynch_d[i*SET_WIDTH +: SET_WIDTH] = cmd_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            asynch_q <= INIT_VALUE;
            synch_q  <= INIT_VALUE;
        end else begin
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            err_q    <= err_d;
            asynch_q <= asynch_d;
            synch_q  <= asynch_q;
        end
    end

    assign cmd_ready          = ready_q;
    assign cmd_done           = done_q;
    assign cmd_err            = err_q;
    assign set_signals_asynch = asynch_q;
    assign set_signals_synch  = synch_q;

endmodule

// File: tb/tb_set_injector.sv
// Directed testbench for set_injector: reset/init, ready delay, writes, errors, back-to-back, priority.
module tb_set_injector;
    import set_injector_pkg::*;

    localparam int N  = 5;
    localparam int W  = 32;
    localparam int AW = 64;
    localparam logic [N*W-1:0] INIT = {32'hFFFFFFFF, 32'h00000000, 32'h55555555,
                                       32'h22222222, 32'hAAAAAAAA};

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*AW-1:0] set_alias;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [AW-1:0]  cmd_alias;
    logic [W-1:0]   cmd_data;
    logic           cmd_done;
    logic           cmd_err;
    logic [N*W-1:0] asy;
    logic [N*W-1:0] syn;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt;
    logic [N*W-1:0] exp_bank;

    set_injector #(
        .SET_SIZE   (N),
        .SET_WIDTH  (W),
        .ALIAS_W    (AW),
        .WAIT_RST   (4),
        .INIT_VALUE (INIT)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .set_alias          (set_alias),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_alias          (cmd_alias),
        .cmd_data           (cmd_data),
        .cmd_done           (cmd_done),
        .cmd_err            (cmd_err),
        .set_signals_asynch (asy),
        .set_signals_synch  (syn)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_alias = '0;
        cmd_data  = '0;
        #2;
        for (int k = 0; k < 3; k++) tick();
        n_cmp++; if (asy !== INIT) begin n_err++; $display("FAIL reset_asynch got=%h exp=%h", asy, INIT); end
        n_cmp++; if (syn !== INIT) begin n_err++; $display("FAIL reset_synch got=%h exp=%h", syn, INIT); end
        n_cmp++; if ({cmd_ready, cmd_done, cmd_err} !== 3'b000) begin
            n_err++; $display("FAIL reset_ctrl got=%b exp=000", {cmd_ready, cmd_done, cmd_err});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_early_cmd();
        cmd_valid = 1'b1;
        cmd_alias = pack_alias("I1");
        cmd_data  = 32'h12345678;
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) cmd_valid = 1'b0;
            tick();
            n_cmp++; if (cmd_ready !== (k == 4)) begin
                n_err++; $display("FAIL ready_edge%0d got=%b exp=%b", k, cmd_ready, (k == 4));
            end
            n_cmp++; if ({cmd_done, cmd_err} !== 2'b00) begin
                n_err++; $display("FAIL early_pulse%0d got=%b exp=00", k, {cmd_done, cmd_err});
            end
        end
        n_cmp++; if (asy[1*W +: W] !== 32'h22222222) begin
            n_err++; $display("FAIL early_ch1 got=%h exp=22222222", asy[1*W +: W]);
        end
    endtask

    task automatic test_basic_set();
        exp_bank = INIT;
        cmd_valid = 1'b1;
        cmd_alias = pack_alias("I2");
        cmd_data  = 32'hDEADBEEF;
        tick();
        cmd_valid = 1'b0;
        exp_bank[2*W +: W] = 32'hDEADBEEF;
        n_cmp++; if (asy !== exp_bank) begin n_err++; $display("FAIL set_asynch got=%h exp=%h", asy, exp_bank); end
        n_cmp++; if (syn[2*W +: W] !== 32'h55555555) begin
            n_err++; $display("FAIL set_synch_early got=%h exp=55555555", syn[2*W +: W]);
        end
        n_cmp++; if ({cmd_done, cmd_err} !== 2'b10) begin
            n_err++; $display("FAIL set_pulse got=%b exp=10", {cmd_done, cmd_err});
        end
        tick();
        n_cmp++; if (syn !== exp_bank) begin n_err++; $display("FAIL set_synch got=%h exp=%h", syn, exp_bank); end
        n_cmp++; if (cmd_done !== 1'b0) begin n_err++; $display("FAIL set_done_drop got=%b exp=0", cmd_done); end
    endtask

    task automatic test_unknown_alias();
        cmd_valid = 1'b1;
        cmd_alias = pack_alias("I9");
        cmd_data  = 32'h0000CAFE;
        tick();
        cmd_valid = 1'b0;
        n_cmp++; if ({cmd_done, cmd_err} !== 2'b01) begin
            n_err++; $display("FAIL unk_pulse got=%b exp=01", {cmd_done, cmd_err});
        end
        n_cmp++; if (asy !== exp_bank) begin n_err++; $display("FAIL unk_asynch got=%h exp=%h", asy, exp_bank); end
        tick();
        n_cmp++; if (cmd_err !== 1'b0) begin n_err++; $display("FAIL unk_err_drop got=%b exp=0", cmd_err); end
        n_cmp++; if (syn !== exp_bank) begin n_err++; $display("FAIL unk_synch got=%h exp=%h", syn, exp_bank); end
    endtask

    task automatic test_back_to_back();
        done_cnt  = 0;
        cmd_valid = 1'b1;
        cmd_alias = pack_alias("I0");
        cmd_data  = 32'd1;
        tick();
        done_cnt += int'(cmd_done);
        n_cmp++; if (asy[0 +: W] !== 32'd1) begin n_err++; $display("FAIL b2b_a0_1 got=%h exp=1", asy[0 +: W]); end
        cmd_data = 32'd2;
        tick();
        done_cnt += int'(cmd_done);
        n_cmp++; if (asy[0 +: W] !== 32'd2) begin n_err++; $display("FAIL b2b_a0_2 got=%h exp=2", asy[0 +: W]); end
        n_cmp++; if (syn[0 +: W] !== 32'd1) begin n_err++; $display("FAIL b2b_s0_1 got=%h exp=1", syn[0 +: W]); end
        cmd_alias = pack_alias("I4");
        cmd_data  = 32'd3;
        tick();
        done_cnt += int'(cmd_done);
        cmd_valid = 1'b0;
        n_cmp++; if (syn[0 +: W] !== 32'd2) begin n_err++; $display("FAIL b2b_s0_2 got=%h exp=2", syn[0 +: W]); end
        tick();
        done_cnt += int'(cmd_done);
        exp_bank[0*W +: W] = 32'd2;
        exp_bank[4*W +: W] = 32'd3;
        n_cmp++; if (asy !== exp_bank) begin n_err++; $display("FAIL b2b_asynch got=%h exp=%h", asy, exp_bank); end
        n_cmp++; if (syn !== exp_bank) begin n_err++; $display("FAIL b2b_synch got=%h exp=%h", syn, exp_bank); end
        n_cmp++; if (done_cnt !== 3) begin n_err++; $display("FAIL b2b_done_count got=%0d exp=3", done_cnt); end
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1;
        cmd_alias = pack_alias("I3");
        cmd_data  = 32'h00000077;
        tick();
        cmd_valid = 1'b0;
        n_cmp++; if (cmd_done !== 1'b1) begin n_err++; $display("FAIL mid_done_pre got=%b exp=1", cmd_done); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({cmd_ready, cmd_done, cmd_err} !== 3'b000) begin
            n_err++; $display("FAIL mid_ctrl got=%b exp=000", {cmd_ready, cmd_done, cmd_err});
        end
        n_cmp++; if (asy !== INIT) begin n_err++; $display("FAIL mid_asynch got=%h exp=%h", asy, INIT); end
        n_cmp++; if (syn !== INIT) begin n_err++; $display("FAIL mid_synch got=%h exp=%h", syn, INIT); end
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_cmp++; if (cmd_ready !== (k == 4)) begin
                n_err++; $display("FAIL rearm_edge%0d got=%b exp=%b", k, cmd_ready, (k == 4));
            end
        end
    endtask

    task automatic test_priority();
        set_alias[3*AW +: AW] = pack_alias("I1");
        cmd_valid = 1'b1;
        cmd_alias = pack_alias("I1");
        cmd_data  = 32'h0000ABCD;
        tick();
        cmd_valid = 1'b0;
        exp_bank = INIT;
        exp_bank[1*W +: W] = 32'h0000ABCD;
        n_cmp++; if (asy !== exp_bank) begin n_err++; $display("FAIL prio_asynch got=%h exp=%h", asy, exp_bank); end
        n_cmp++; if ({cmd_done, cmd_err} !== 2'b10) begin
            n_err++; $display("FAIL prio_pulse got=%b exp=10", {cmd_done, cmd_err});
        end
    endtask

    initial begin
        set_alias = {pack_alias("I4"), pack_alias("I3"), pack_alias("I2"),
                     pack_alias("I1"), pack_alias("I0")};
        test_reset();
        test_early_cmd();
        test_basic_set();
        test_unknown_alias();
        test_back_to_back();
        test_reset_mid();
        test_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
